switch_debounce_io: RTL and testbench

Parametrised memory-mapped switch/button input peripheral for the miniLA CPU I/O bus. Up to 32 board inputs are synchronised, optionally debounced per channel, and exposed as debounced-state, sticky-edge, interrupt-mask and raw-sync registers. A level interrupt request goes to the CPU when any enabled edge flag is set. It replaces the plain registered switch reader with a generalised width and added change-detection and interrupt behaviour.

---
 rtl/switch_debounce_io.sv | 123 ++++++++++++
 tb/tb_switch_debounce_io.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_io.sv
// Memory-mapped switch/button input block: per-channel sync + debounce, sticky edge flags, mask, level irq.
// Define SW_DEBOUNCE_EN to build the debounce counters; otherwise STATE follows the synchroniser directly.

module switch_debounce_lane #(
  parameter int DB_LIMIT = 500000,
  parameter int DB_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic raw,
  output logic stable,
  output logic hit
);
  logic sync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      raw   <= 1'b0;
    end else begin
      sync1 <= din;
      raw   <= sync1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [DB_W-1:0] cnt;

  // A new level is only accepted after DB_LIMIT consecutive disagreeing samples.
  assign hit = (raw != stable) && (cnt == DB_W'(DB_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (hit) begin
      stable <= raw;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign hit = (raw != stable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable <= 1'b0;
    else     stable <= raw;
  end
`endif
endmodule

module switch_debounce_io #(
  parameter int N_SW     = 16,
  parameter int DB_LIMIT = 500000,
  parameter int DB_W     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_input,
  input  logic [1:0]      sel,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);
  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_EDGE  = 2'd1,
    REG_MASK  = 2'd2,
    REG_RAW   = 2'd3
  } reg_sel_t;

  logic [N_SW-1:0] raw, state, hit, edge_flags, mask, clr;
  logic [31:0]     rd;
  logic            unused_wdata;

  assign unused_wdata = ^wdata;

  for (genvar i = 0; i < N_SW; i++) begin : g_lane
    switch_debounce_lane #(
      .DB_LIMIT (DB_LIMIT),
      .DB_W     (DB_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .din    (sw_input[i]),
      .raw    (raw[i]),
      .stable (state[i]),
      .hit    (hit[i])
    );
  end

  assign clr = (we && sel == REG_EDGE) ? wdata[N_SW-1:0] : '0;

  always_comb begin
    rd = '0;
    case (reg_sel_t'(sel))
      REG_STATE: rd[N_SW-1:0] = state;
      REG_EDGE:  rd[N_SW-1:0] = edge_flags;
      REG_MASK:  rd[N_SW-1:0] = mask;
      default:   rd[N_SW-1:0] = raw;
    endcase
  end

  // Set is OR-ed after the clear so a same-cycle accept survives a W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_flags <= '0;
      mask       <= '0;
      rdata      <= '0;
      irq        <= 1'b0;
    end else begin
      edge_flags <= (edge_flags & ~clr) | hit;
      if (we && sel == REG_MASK) mask <= wdata[N_SW-1:0];
      rdata <= rd;
      irq   <= |(edge_flags & mask);
    end
  end
endmodule

// File: tb/tb_switch_debounce_io.sv
// Randomized + directed bench for switch_debounce_io against a sample-history reference model.
module tb_switch_debounce_io;
  localparam int N = 16;
`ifdef SW_DEBOUNCE_EN
  localparam int L = 4;
`else
  localparam int L = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  sw_input = '0;
  logic [1:0]    sel = 2'd0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          irq;

  switch_debounce_io #(.N_SW(N), .DB_LIMIT(4), .DB_W(20)) dut (
    .clk(clk), .rst(rst), .sw_input(sw_input), .sel(sel),
    .we(we), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference: a level is accepted once the last L synchronised samples all disagree with it.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_edge = '0, m_mask = '0;
  logic [31:0]  m_rd = '0;
  logic         m_irq = 1'b0;
  logic [N-1:0] hist[$];

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] acc, clr;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_edge = '0; m_mask = '0;
      m_rd = '0; m_irq = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > L) void'(hist.pop_front());
      acc = (hist.size() == L) ? '1 : '0;
      foreach (hist[i]) acc &= hist[i] ^ m_st;
      clr = (we && sel == 2'd1) ? wdata[N-1:0] : '0;
      m_irq = |(m_edge & m_mask);
      case (sel)
        2'd0:    m_rd = {16'h0, m_st};
        2'd1:    m_rd = {16'h0, m_edge};
        2'd2:    m_rd = {16'h0, m_mask};
        default: m_rd = {16'h0, m_s2};
      endcase
      if (we && sel == 2'd2) m_mask = wdata[N-1:0];
      m_edge = (m_edge & ~clr) | acc;
      m_st   = m_st ^ acc;
      m_s2   = m_s1;
      m_s1   = sw_input;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("rdata_model", rdata, m_rd);
    chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    sel = s; we = 1'b1; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] s, input logic [31:0] exp);
    sel = s;
    step();
    chk(tag, rdata, exp);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) read_chk("rst_reg", 2'(s), 32'h0);

    // Debounce accept with exact latency
    wr(2'd2, 32'h4);
    sel = 2'd0;
    sw_input = 16'h0005;
    repeat (L + 2) step();
    chk("accept_early_state", rdata, 32'h0);
    chk("accept_early_irq", {31'b0, irq}, 32'h0);
    step();
    chk("accept_state", rdata, 32'h5);
    chk("accept_irq", {31'b0, irq}, 32'h1);
    read_chk("accept_edge", 2'd1, 32'h5);

    // Register map
    wr(2'd2, 32'hFFFF_FFFF);
    read_chk("mask_width", 2'd2, 32'h0000_FFFF);
    wr(2'd0, 32'hDEAD_BEEF);
    wr(2'd3, 32'h1234_5678);
    read_chk("state_ro", 2'd0, 32'h5);
    read_chk("raw_ro", 2'd3, 32'h5);

    // W1C all flags, irq drops
    wr(2'd1, 32'hFFFF_FFFF);
    step();
    chk("w1c_all", rdata, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'h0);

    // Glitch on bit 3 for 3 cycles; RAW shows it 2 cycles late
    sel = 2'd3;
    sw_input = 16'h000D;
    step(); step();
    chk("raw_pre", rdata, 32'h5);
    step();
    chk("raw_pulse", rdata, 32'hD);
    sw_input = 16'h0005;
    repeat (L + 4) step();
    read_chk("glitch_state", 2'd0, 32'h5);
`ifdef SW_DEBOUNCE_EN
    read_chk("glitch_edge", 2'd1, 32'h0);
`else
    read_chk("glitch_edge", 2'd1, 32'h8);
`endif

    // W1C colliding with a fresh accept on bit 0
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'h1);
    sel = 2'd0;
    sw_input = 16'h0004;
    step();
    repeat (L) step();
    sel = 2'd1; we = 1'b1; wdata = 32'h1;
    step();
    we = 1'b0;
    step();
    chk("collide_edge", rdata, 32'h1);
    chk("collide_irq", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h1);
    chk("clear_irq_hold", {31'b0, irq}, 32'h1);
    step();
    chk("clear_irq_drop", {31'b0, irq}, 32'h0);
    chk("clear_edge", rdata, 32'h0);

    // Reset in the middle of a debounce window
    wr(2'd2, 32'hFFFF_FFFF);
    sw_input = 16'hFFFF;
    repeat (L + 4) step();
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    sw_input = 16'h0000;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (L + 4) step();
    for (int s = 0; s < 4; s++) read_chk("post_rst_reg", 2'(s), 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) sw_input = N'($urandom);
      else if (r < 4) sw_input[$urandom_range(0, N - 1)] ^= 1'b1;
      sel = 2'($urandom);
      we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      step();
      we = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
